// File: rtl/chan_irq_pkg.sv
// chan_irq_pkg: shared types and defaults for the channel interrupt arbiter.
// Holds the FSM state enum, channel/ID width defaults and a priority helper.
package chan_irq_pkg;

   localparam int N_CHAN_DEF = 9;
   localparam int ID_W_DEF   = 4;

   typedef enum logic [1:0] {
      IDLE,
      OFFER,
      SERVICE
   } state_t;

   // Returns {found, index}; lowest set index wins.
   function automatic logic [ID_W_DEF:0] prio_enc(
      input logic [N_CHAN_DEF-1:0] v
   );
      logic [ID_W_DEF:0] r;
      r = '0;
      for (int k = N_CHAN_DEF - 1; k >= 0; k--) begin
         if (v[k]) r = {1'b1, ID_W_DEF'(k)};
      end
      return r;
   endfunction

endpackage

// File: rtl/chan_irq_arbiter_if.sv
// chan_irq_arbiter_if: grant handshake between arbiter and processor.
// master: drives irq_valid/irq_id/in_service; slave: drives irq_ack/eoi.
interface chan_irq_arbiter_if #(
   parameter int ID_W = chan_irq_pkg::ID_W_DEF
);

   logic            irq_valid;
   logic [ID_W-1:0] irq_id;
   logic            irq_ack;
   logic            eoi;
   logic            in_service;

   modport master (
      output irq_valid,
      output irq_id,
      output in_service,
      input  irq_ack,
      input  eoi
   );

   modport slave (
      input  irq_valid,
      input  irq_id,
      input  in_service,
      output irq_ack,
      output eoi
   );

endinterface

// File: rtl/chan_prio_enc.sv
// chan_prio_enc: combinational fixed-priority encoder, bit 0 highest.
// Ports: vec (request bits) in; idx (winning index), any (vec != 0) out.
module chan_prio_enc
   import chan_irq_pkg::*;
#(
   parameter int N = N_CHAN_DEF,
   parameter int W = ID_W_DEF
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         any
);

   // Scan downward so the lowest set bit is the last one written.
   always_comb begin
      idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (vec[k]) idx = W'(k);
      end
   end

   assign any = |vec;

endmodule

// File: rtl/chan_irq_arbiter.sv
// chan_irq_arbiter: sticky pending bits, fixed-priority grant, valid/ack offer.
// Ports: clk, rst, req_i in; bus (master); pending, timeout_cnt out.
module chan_irq_arbiter
   import chan_irq_pkg::*;
#(
   parameter int N_CHAN      = N_CHAN_DEF,
   parameter int ID_W        = ID_W_DEF,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CHAN-1:0] req_i,
   chan_irq_arbiter_if.master bus,
   output logic [N_CHAN-1:0] pending,
   output logic [7:0]        timeout_cnt
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);

   state_t            state;
   state_t            state_n;
   logic [N_CHAN-1:0] pending_n;
   logic [N_CHAN-1:0] clr_mask;
   logic              valid_n;
   logic [ID_W-1:0]   id_n;
   logic              svc_n;
   logic [TW-1:0]     timer;
   logic [TW-1:0]     timer_n;
   logic [7:0]        tcnt_n;
   logic [ID_W-1:0]   top_idx;
   logic              any;

   chan_prio_enc #(
      .N (N_CHAN),
      .W (ID_W)
   ) u_enc (
      .vec (pending),
      .idx (top_idx),
      .any (any)
   );

   always_comb begin
      state_n  = state;
      valid_n  = bus.irq_valid;
      id_n     = bus.irq_id;
      svc_n    = bus.in_service;
      timer_n  = timer;
      tcnt_n   = timeout_cnt;
      clr_mask = '0;
      unique case (state)
         IDLE: begin
            if (any) begin
               state_n = OFFER;
               valid_n = 1'b1;
               id_n    = top_idx;
               timer_n = TW'(1);
            end
         end
         OFFER: begin
            // Ack beats a timeout landing in the same cycle.
            if (bus.irq_ack) begin
               clr_mask = N_CHAN'(1) << bus.irq_id;
               valid_n  = 1'b0;
               svc_n    = 1'b1;
               timer_n  = '0;
               state_n  = SERVICE;
            end else if (timer == TW'(ACK_TIMEOUT)) begin
               valid_n = 1'b0;
               timer_n = '0;
               state_n = IDLE;
               if (timeout_cnt != 8'hFF) tcnt_n = timeout_cnt + 8'd1;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         SERVICE: begin
            if (bus.eoi) begin
               svc_n   = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      // Clear wins over a same-cycle request on the accepted channel.
      pending_n = (pending | req_i) & ~clr_mask;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         pending        <= '0;
         bus.irq_valid  <= 1'b0;
         bus.irq_id     <= '0;
         bus.in_service <= 1'b0;
         timer          <= '0;
         timeout_cnt    <= '0;
      end else begin
         state          <= state_n;
         pending        <= pending_n;
         bus.irq_valid  <= valid_n;
         bus.irq_id     <= id_n;
         bus.in_service <= svc_n;
         timer          <= timer_n;
         timeout_cnt    <= tcnt_n;
      end
   end

endmodule

// File: tb/tb_chan_irq_arbiter.sv
// tb_chan_irq_arbiter: scoreboard bench for chan_irq_arbiter.
// Expected grant ids are queued at stimulus time and popped at each offer.
module tb_chan_irq_arbiter;

   logic       clk;
   logic       rst;
   logic [8:0] req_i;
   logic [8:0] pending;
   logic [7:0] timeout_cnt;

   int n_chk;
   int n_pass;
   int q[$];

   chan_irq_arbiter_if #(.ID_W(4)) bus ();

   chan_irq_arbiter #(
      .N_CHAN      (9),
      .ID_W        (4),
      .ACK_TIMEOUT (15)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_i       (req_i),
      .bus         (bus),
      .pending     (pending),
      .timeout_cnt (timeout_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(
      input string       tag,
      input logic [31:0] got,
      input logic [31:0] exp
   );
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int pop_exp();
      if (q.size() == 0) return -1;
      return q.pop_front();
   endfunction

   task automatic wait_offer(input string tag);
      int n;
      n = 0;
      while (!bus.irq_valid && n < 50) begin
         tick();
         n++;
      end
      chk({tag, "_offer"}, 32'(bus.irq_valid), 32'd1);
   endtask

   // Accept the next offer, check it, then eoi dly cycles after the ack.
   task automatic take(
      input string      tag,
      input int         dly,
      input logic [8:0] exp_pend
   );
      wait_offer(tag);
      chk({tag, "_id"}, 32'(bus.irq_id), 32'(pop_exp()));
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      chk({tag, "_svc"}, 32'(bus.in_service), 32'd1);
      chk({tag, "_vld0"}, 32'(bus.irq_valid), 32'd0);
      chk({tag, "_pend"}, 32'(pending), 32'(exp_pend));
      for (int i = 1; i < dly; i++) begin
         tick();
         chk({tag, "_svch"}, 32'(bus.in_service), 32'd1);
      end
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;
      chk({tag, "_eoi"}, 32'(bus.in_service), 32'd0);
   endtask

   initial begin
      int cnt;
      n_chk       = 0;
      n_pass      = 0;
      rst         = 1'b1;
      req_i       = '0;
      bus.irq_ack = 1'b0;
      bus.eoi     = 1'b0;
      tick();

      // 1: reset with all requests high, then priority drain
      req_i = 9'h1FF;
      tick();
      chk("rst_vld", 32'(bus.irq_valid), 32'd0);
      chk("rst_id", 32'(bus.irq_id), 32'd0);
      chk("rst_svc", 32'(bus.in_service), 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);
      chk("rst_tcnt", 32'(timeout_cnt), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 9; k++) q.push_back(k);
      tick();
      req_i = '0;
      chk("t1_latch", 32'(pending), 32'h1FF);
      chk("t1_vld_early", 32'(bus.irq_valid), 32'd0);
      tick();
      chk("t1_vld", 32'(bus.irq_valid), 32'd1);
      chk("t1_id0", 32'(bus.irq_id), 32'd0);
      for (int k = 0; k < 9; k++) begin
         take($sformatf("t1_ch%0d", k), 1, 9'(9'h1FF << (k + 1)));
      end

      // 2: ch5 and ch8 in one pulse
      req_i = 9'b100100000;
      q.push_back(5);
      q.push_back(8);
      tick();
      req_i = '0;
      chk("t2_pend", 32'(pending), 32'h120);
      take("t2a", 3, 9'h100);
      take("t2b", 3, 9'h000);

      // 3: no re-arbitration while an offer is outstanding
      req_i = 9'h010;
      q.push_back(4);
      q.push_back(1);
      tick();
      req_i = '0;
      tick();
      chk("t3_vld", 32'(bus.irq_valid), 32'd1);
      req_i = 9'h002;
      tick();
      req_i = '0;
      tick();
      chk("t3_hold", 32'(bus.irq_id), 32'd4);
      take("t3a", 1, 9'h002);
      take("t3b", 1, 9'h000);

      // 4: timeout, re-offer, then ack on the last allowed cycle
      req_i = 9'h004;
      q.push_back(2);
      tick();
      req_i = '0;
      tick();
      chk("t4_vld", 32'(bus.irq_valid), 32'd1);
      cnt = 0;
      while (bus.irq_valid && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("t4_len", 32'(cnt), 32'd15);
      chk("t4_tcnt", 32'(timeout_cnt), 32'd1);
      chk("t4_keep", 32'(pending), 32'h004);
      tick();
      chk("t4_reoff", 32'(bus.irq_valid), 32'd1);
      chk("t4_reid", 32'(bus.irq_id), 32'(pop_exp()));
      repeat (14) tick();
      chk("t4_c15", 32'(bus.irq_valid), 32'd1);
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      chk("t4_ack", 32'(bus.in_service), 32'd1);
      chk("t4_tcnt2", 32'(timeout_cnt), 32'd1);
      chk("t4_pend", 32'(pending), 32'd0);
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;

      // 5: same-cycle clear and set on ch3
      req_i = 9'h008;
      q.push_back(3);
      tick();
      req_i = '0;
      tick();
      chk("t5_id", 32'(bus.irq_id), 32'(pop_exp()));
      bus.irq_ack = 1'b1;
      req_i = 9'h008;
      tick();
      bus.irq_ack = 1'b0;
      chk("t5_lost", 32'(pending), 32'd0);
      req_i = 9'h008;
      q.push_back(3);
      tick();
      req_i = '0;
      chk("t5_set", 32'(pending), 32'h008);
      chk("t5_novld", 32'(bus.irq_valid), 32'd0);
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;
      take("t5b", 1, 9'h000);

      // 6: reset while in service with pending work
      req_i = 9'h001;
      q.push_back(0);
      tick();
      req_i = '0;
      tick();
      chk("t6_id", 32'(bus.irq_id), 32'(pop_exp()));
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
      req_i = 9'h0F0;
      tick();
      req_i = '0;
      chk("t6_pend", 32'(pending), 32'h0F0);
      chk("t6_svc", 32'(bus.in_service), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_rpend", 32'(pending), 32'd0);
      chk("t6_rsvc", 32'(bus.in_service), 32'd0);
      chk("t6_rvld", 32'(bus.irq_valid), 32'd0);
      chk("t6_rtcnt", 32'(timeout_cnt), 32'd0);
      bus.eoi = 1'b1;
      tick();
      bus.eoi = 1'b0;
      tick();
      chk("t6_eoi_svc", 32'(bus.in_service), 32'd0);
      chk("t6_eoi_vld", 32'(bus.irq_valid), 32'd0);
      chk("t6_eoi_pend", 32'(pending), 32'd0);
      chk("sb_empty", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
